multi_timer: RTL

//   N-channel countdown timer sharing one tick prescaler off clk_104mhz. Each channel latches a

---
 rtl/multi_timer_pkg.sv | 9 +
 rtl/timer_channel.sv | 88 ++++++++
 rtl/multi_timer.sv | 66 ++++++
 3 files changed

// File: rtl/multi_timer_pkg.sv
// rtl/multi_timer_pkg.sv - shared state/mode types and default prescaler divide for multi_timer
package multi_timer_pkg;

  typedef enum logic {IDLE, COUNTING} tmr_state_t;
  typedef enum logic {ONE_SHOT, PERIODIC} tmr_mode_t;

  localparam int DEFAULT_TICK_DIV = 104_000_000;

endpackage

// File: rtl/timer_channel.sv
// rtl/timer_channel.sv - one countdown channel: FSM, count and reload registers
module timer_channel
  import multi_timer_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk_104mhz,
  input  logic             reset,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic [CNT_W-1:0] value,
  output logic             expired,
  output logic             busy,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  tmr_state_t       r_state, w_state_nxt;
  tmr_mode_t        r_mode, w_mode_nxt;
  logic [CNT_W-1:0] r_count, w_count_nxt;
  logic [CNT_W-1:0] r_reload, w_reload_nxt;
  logic             r_expired, w_expired_nxt;

  always_ff @(posedge clk_104mhz or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_mode    <= ONE_SHOT;
      r_count   <= '0;
      r_reload  <= '0;
      r_expired <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_mode    <= w_mode_nxt;
      r_count   <= w_count_nxt;
      r_reload  <= w_reload_nxt;
      r_expired <= w_expired_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_mode_nxt    = r_mode;
    w_count_nxt   = r_count;
    w_reload_nxt  = r_reload;
    w_expired_nxt = 1'b0;
    if (start) begin
      w_state_nxt  = COUNTING;
      w_count_nxt  = value;
      w_reload_nxt = value;
      w_mode_nxt   = periodic ? PERIODIC : ONE_SHOT;
    end else if (stop) begin
      w_state_nxt = IDLE;
      w_count_nxt = '0;
    end else begin
      case (r_state)
        IDLE: w_count_nxt = '0;
        COUNTING: begin
          // A zero load expires on the next cycle regardless of tick and never reloads.
          if (r_count == '0) begin
            w_expired_nxt = 1'b1;
            w_state_nxt   = IDLE;
          end else if (tick) begin
            if (r_count == ONE) begin
              w_expired_nxt = 1'b1;
              if (r_mode == PERIODIC) begin
                w_count_nxt = r_reload;
              end else begin
                w_count_nxt = '0;
                w_state_nxt = IDLE;
              end
            end else begin
              w_count_nxt = r_count - ONE;
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign expired = r_expired;
  assign busy    = (r_state == COUNTING);
  assign count   = r_count;

endmodule

// File: rtl/multi_timer.sv
// rtl/multi_timer.sv - N-channel countdown timer with shared tick prescaler (optional MULTI_TIMER_PAUSE_EN)
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int CNT_W    = 8,
  parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic                  clk_104mhz,
  input  logic                  reset,
  input  logic [N_CH-1:0]       start,
  input  logic [N_CH-1:0]       stop,
  input  logic [N_CH-1:0]       periodic,
  input  logic [N_CH*CNT_W-1:0] value,
`ifdef MULTI_TIMER_PAUSE_EN
  input  logic                  pause,
`endif
  output logic [N_CH-1:0]       expired,
  output logic [N_CH-1:0]       busy,
  output logic [N_CH*CNT_W-1:0] count
);

  localparam int            PW   = $clog2(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] r_presc;
  logic          r_tick;
  logic          w_run;

`ifdef MULTI_TIMER_PAUSE_EN
  assign w_run = ~pause;
`else
  assign w_run = 1'b1;
`endif

  // Free-running; a start never realigns the tick phase.
  always_ff @(posedge clk_104mhz or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else if (w_run) begin
      r_tick  <= (r_presc == LAST);
      r_presc <= (r_presc == LAST) ? '0 : r_presc + PW'(1);
    end else begin
      r_tick  <= 1'b0;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    timer_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk_104mhz(clk_104mhz),
      .reset     (reset),
      .tick      (r_tick),
      .start     (start[g]),
      .stop      (stop[g]),
      .periodic  (periodic[g]),
      .value     (value[g*CNT_W +: CNT_W]),
      .expired   (expired[g]),
      .busy      (busy[g]),
      .count     (count[g*CNT_W +: CNT_W])
    );
  end

endmodule
